// File: rtl/ula_pkg.sv
// ula_pkg: opcode and FSM state encodings shared by the sequential ULA
// and its combinational single-cycle datapath.
package ula_pkg;

  // 4-bit opcodes; anything not listed is treated as an illegal single-cycle op
  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_XOR = 4'b0100;
  localparam logic [3:0] OP_SLT = 4'b0101;
  localparam logic [3:0] OP_SLL = 4'b0110;
  localparam logic [3:0] OP_SRL = 4'b0111;
  localparam logic [3:0] OP_SRA = 4'b1000;
  localparam logic [3:0] OP_MUL = 4'b1001;

  // FSM state encoding
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] MUL   = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  // Everything except the serial shifts and the multiplier finishes in one cycle
  function automatic logic is_single_cycle(input logic [3:0] op);
    return !(op == OP_SLL || op == OP_SRL || op == OP_SRA || op == OP_MUL);
  endfunction

endpackage

// File: rtl/ula_comb.sv
// ula_comb: combinational single-cycle datapath.
//   a, b   : operands
//   f      : opcode
//   result : ADD/SUB/AND/OR/XOR/SLT result, 0 for any other code
//   c, v   : carry out / signed overflow for ADD and SUB, else 0
module ula_comb
  import ula_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       f,
  output logic [WIDTH-1:0] result,
  output logic             c,
  output logic             v
);

  logic             sub;
  logic [WIDTH-1:0] bx;
  logic [WIDTH:0]   full;
  logic             c_msb;
  logic             v_as;

  // SUB and SLT both use A + ~B + 1
  assign sub  = (f != OP_ADD);
  assign bx   = sub ? ~b : b;
  assign full = {1'b0, a} + {1'b0, bx} + (WIDTH+1)'(sub);

  // carry into the MSB recovered from the MSB sum bit: s = a ^ b ^ cin
  assign c_msb = a[WIDTH-1] ^ bx[WIDTH-1] ^ full[WIDTH-1];
  assign v_as  = c_msb ^ full[WIDTH];

  always_comb begin
    result = '0;
    c      = 1'b0;
    v      = 1'b0;
    case (f)
      OP_ADD, OP_SUB: begin
        result = full[WIDTH-1:0];
        c      = full[WIDTH];
        v      = v_as;
      end
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      // signed less-than: sign of the difference corrected by overflow
      OP_SLT: result = WIDTH'(full[WIDTH-1] ^ v_as);
      default: ;
    endcase
  end

endmodule

// File: rtl/ula_seq.sv
// ula_seq: multi-cycle ULA with valid/ready handshake on both sides.
//   clk, rst             : clock, synchronous active-high reset
//   in_valid / in_ready  : operation handshake (A, B, f latched on accept)
//   A, B, f              : operands and opcode; shifts use B[SHW-1:0]
//   out_valid / out_ready: result handshake
//   saida, z, n, c, v    : result and flags, held while out_valid && !out_ready
// Shifts move one bit per cycle; MUL is a WIDTH-cycle shift-add.
module ula_seq
  import ula_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       f,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] saida,
  output logic             z,
  output logic             n,
  output logic             c,
  output logic             v
);

  localparam int SHW = $clog2(WIDTH);
  // counter must hold WIDTH itself for the multiplier
  localparam int CW  = $clog2(WIDTH + 1);

  logic [1:0]       state;
  logic [3:0]       op;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] sh, acc, mcand, mplier;
  logic [WIDTH-1:0] sh_nxt, acc_nxt;
  logic [SHW-1:0]   amt;
  logic             last;

  logic [WIDTH-1:0] comb_res;
  logic             comb_c, comb_v;

  logic             ld;
  logic [WIDTH-1:0] ld_val;
  logic             ld_c, ld_v;

  ula_comb #(.WIDTH(WIDTH)) u_comb (
    .a      (A),
    .b      (B),
    .f      (f),
    .result (comb_res),
    .c      (comb_c),
    .v      (comb_v)
  );

  assign amt       = B[SHW-1:0];
  assign last      = (cnt == CW'(1));
  assign in_ready  = (state == IDLE) && !rst;
  assign out_valid = (state == DONE);

  always_comb begin
    case (op)
      OP_SLL:  sh_nxt = sh << 1;
      OP_SRL:  sh_nxt = sh >> 1;
      default: sh_nxt = {sh[WIDTH-1], sh[WIDTH-1:1]};
    endcase
  end

  assign acc_nxt = mplier[0] ? acc + mcand : acc;

  // Result load: the one place saida/flags are written, so they stay
  // frozen through DONE regardless of backpressure.
  always_comb begin
    ld     = 1'b0;
    ld_val = '0;
    ld_c   = 1'b0;
    ld_v   = 1'b0;
    case (state)
      IDLE: if (in_valid && in_ready) begin
        if (is_single_cycle(f)) begin
          ld     = 1'b1;
          ld_val = comb_res;
          ld_c   = comb_c;
          ld_v   = comb_v;
        end else if (f != OP_MUL && amt == '0) begin
          ld     = 1'b1;
          ld_val = A;
        end
      end
      SHIFT: if (last) begin
        ld     = 1'b1;
        ld_val = sh_nxt;
      end
      MUL: if (last) begin
        ld     = 1'b1;
        ld_val = acc_nxt;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      op     <= OP_ADD;
      cnt    <= '0;
      sh     <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      saida  <= '0;
      z      <= 1'b0;
      n      <= 1'b0;
      c      <= 1'b0;
      v      <= 1'b0;
    end else begin
      if (ld) begin
        saida <= ld_val;
        z     <= (ld_val == '0);
        n     <= ld_val[WIDTH-1];
        c     <= ld_c;
        v     <= ld_v;
      end
      case (state)
        IDLE: if (in_valid) begin
          op <= f;
          if (is_single_cycle(f)) begin
            state <= DONE;
          end else if (f == OP_MUL) begin
            acc    <= '0;
            mcand  <= A;
            mplier <= B;
            cnt    <= CW'(WIDTH);
            state  <= MUL;
          end else if (amt == '0) begin
            state <= DONE;
          end else begin
            sh    <= A;
            cnt   <= CW'(amt);
            state <= SHIFT;
          end
        end
        SHIFT: begin
          sh  <= sh_nxt;
          cnt <= cnt - CW'(1);
          if (last) state <= DONE;
        end
        MUL: begin
          acc    <= acc_nxt;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt - CW'(1);
          if (last) state <= DONE;
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ula_seq.sv
// Scoreboard bench for ula_seq: the driver pushes hand-computed results with
// their expected presentation cycle; a monitor pops on each new out_valid.
module tb_ula_seq;

  localparam int W = 32;

  logic         clk, rst, in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0] A, B, saida;
  logic [3:0]   f;
  logic         z, n, c, v;

  ula_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .f(f), .out_valid(out_valid), .out_ready(out_ready),
    .saida(saida), .z(z), .n(n), .c(c), .v(v)
  );

  typedef struct {
    logic [W-1:0] r;
    logic         z, n, c, v;
    int           cyc;
  } exp_t;

  exp_t q[$];
  exp_t cur;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  bit   presenting = 0;
  bit   hs_prev    = 0;

  initial clk = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  // lat: cycles from accept until out_valid is visible
  task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] r, input logic ez, input logic en,
                       input logic ec, input logic ev, input int lat, input bit push);
    int t = 0;
    @(negedge clk);
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("issue_timeout", 64'(t >= 200), 64'(0));
    in_valid = 1; A = a; B = b; f = op;
    if (push) q.push_back('{r: r, z: ez, n: en, c: ec, v: ev, cyc: cyc + lat});
    @(negedge clk);
    in_valid = 0;
  endtask

  task automatic drain();
    int t = 0;
    while ((q.size() != 0 || out_valid) && t < 300) begin
      @(negedge clk);
      t++;
    end
    chk("drain_timeout", 64'(t >= 300), 64'(0));
  endtask

  // monitor: samples just after the falling edge, when driven inputs are settled
  initial forever begin
    @(negedge clk);
    #1;
    if (rst) begin
      presenting = 0;
      hs_prev    = 0;
    end else begin
      if (hs_prev) chk("in_ready_after_handshake", 64'(in_ready), 64'(1));
      if (out_valid) begin
        if (!presenting) begin
          if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output got saida=%h at cycle %0d expected no output", saida, cyc);
            cur = '{r: saida, z: z, n: n, c: c, v: v, cyc: cyc};
          end else begin
            cur = q.pop_front();
            chk("latency_cycle", 64'(cyc), 64'(cur.cyc));
          end
          presenting = 1;
        end
        chk("result_saida", 64'(saida), 64'(cur.r));
        chk("result_flags_zncv", 64'({z, n, c, v}), 64'({cur.z, cur.n, cur.c, cur.v}));
        chk("in_ready_while_done", 64'(in_ready), 64'(0));
      end
      hs_prev = out_valid && out_ready;
      if (hs_prev) presenting = 0;
    end
  end

  initial begin
    int t;
    rst = 1; in_valid = 0; out_ready = 1; A = '0; B = '0; f = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_in_ready", 64'(in_ready), 64'(0));
    chk("reset_out_valid", 64'(out_valid), 64'(0));
    chk("reset_saida_flags", 64'({saida, z, n, c, v}), 64'(0));
    @(negedge clk);
    rst = 0;
    #1;
    chk("in_ready_after_reset", 64'(in_ready), 64'(1));

    //     op      A             B             result        z  n  c  v  lat
    issue(4'b0000, 32'h7FFFFFFF, 32'h1,        32'h80000000, 0, 1, 0, 1, 1,  1);
    issue(4'b0001, 32'd5,        32'd5,        32'h0,        1, 0, 1, 0, 1,  1);
    issue(4'b0001, 32'd0,        32'd1,        32'hFFFFFFFF, 0, 1, 0, 0, 1,  1);
    issue(4'b0001, 32'h80000000, 32'd1,        32'h7FFFFFFF, 0, 0, 1, 1, 1,  1);
    issue(4'b0101, 32'hFFFFFFFF, 32'd1,        32'h1,        0, 0, 0, 0, 1,  1);
    issue(4'b0101, 32'h80000000, 32'd1,        32'h1,        0, 0, 0, 0, 1,  1);
    issue(4'b0101, 32'd1,        32'hFFFFFFFF, 32'h0,        1, 0, 0, 0, 1,  1);
    issue(4'b0011, 32'h00FF0000, 32'h0000FF00, 32'h00FFFF00, 0, 0, 0, 0, 1,  1);
    issue(4'b0100, 32'hAAAA5555, 32'hFFFF0000, 32'h55555555, 0, 0, 0, 0, 1,  1);
    issue(4'b1111, 32'h123,      32'h456,      32'h0,        1, 0, 0, 0, 1,  1);
    issue(4'b0110, 32'h1,        32'd31,       32'h80000000, 0, 1, 0, 0, 32, 1);
    issue(4'b1000, 32'h80000000, 32'd4,        32'hF8000000, 0, 1, 0, 0, 5,  1);
    issue(4'b0111, 32'h12345678, 32'd0,        32'h12345678, 0, 0, 0, 0, 1,  1);
    issue(4'b0111, 32'h80000000, 32'h21,       32'h40000000, 0, 0, 0, 0, 2,  1);
    issue(4'b1000, 32'h7FFFFFFF, 32'd31,       32'h0,        1, 0, 0, 0, 32, 1);
    issue(4'b1001, 32'h80000001, 32'd3,        32'h80000003, 0, 1, 0, 0, 33, 1);

    // MUL with stray in_valid pulses while busy
    issue(4'b1001, 32'h0000FFFF, 32'h00010001, 32'hFFFFFFFF, 0, 1, 0, 0, 33, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1; A = 32'd1; B = 32'd1; f = 4'b0000;
      #1;
      chk("in_ready_busy", 64'(in_ready), 64'(0));
      @(negedge clk);
      in_valid = 0;
    end
    drain();

    // backpressure: hold the result for 5 extra cycles
    out_ready = 0;
    issue(4'b0010, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 0, 1, 0, 0, 1, 1);
    t = 0;
    while (!out_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("backpressure_wait", 64'(t >= 50), 64'(0));
    repeat (5) @(negedge clk);
    out_ready = 1;
    drain();

    // reset mid-MUL: that result must never appear
    issue(4'b1001, 32'h0000FFFF, 32'h00010001, 32'h0, 0, 0, 0, 0, 33, 0);
    repeat (9) @(negedge clk);
    rst = 1;
    #1;
    chk("abort_in_ready_in_rst", 64'(in_ready), 64'(0));
    @(negedge clk);
    rst = 0;
    #1;
    chk("abort_out_valid", 64'(out_valid), 64'(0));
    chk("abort_saida_flags", 64'({saida, z, n, c, v}), 64'(0));
    chk("abort_in_ready", 64'(in_ready), 64'(1));
    repeat (40) @(negedge clk);
    issue(4'b0000, 32'd2, 32'd3, 32'd5, 0, 0, 0, 0, 1, 1);
    drain();
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
